// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with an optional second (skid) entry.
// Define PIPE_STAGE_SKID_EN for the two-entry, registered-in_ready build; otherwise single entry.
`default_nettype none

module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic             ready_q;
  logic             push;
  logic             pop;
  logic             load_main;

  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             load_skid;
  logic             move_skid;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            load_main = 1'b1;
          end else if (push) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_nxt = ONE;
          move_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is a pure flop: it advertises a free skid slot after this edge
  assign in_ready = ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      skid_q  <= '0;
    end else begin
      ready_q <= (state_nxt != FULL);
      if (load_skid) skid_q <= in_data;
    end
  end
`else
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (push) begin
      state_nxt = ONE;
      load_main = 1'b1;
    end else if (pop) begin
      state_nxt = EMPTY;
    end
  end

  // ready_q only masks in_ready until the first edge after reset release
  assign in_ready = ready_q && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= in_data;
`ifdef PIPE_STAGE_SKID_EN
    end else if (move_skid) begin
      main_q <= skid_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg (either build of PIPE_STAGE_SKID_EN).
`default_nettype none

module tb_pipe_stage_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  int max_cnt  = 0;

  pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic [1:0] e_cnt;
    logic       e_ov;
    logic [7:0] e_data;
    logic       e_ir;
    logic [3:0] e_stall;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic fl, logic iv, logic [7:0] d, logic ordy, logic [1:0] e_cnt,
                              logic e_ov, logic [7:0] e_data, logic e_ir, logic [3:0] e_stall);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_data = e_data; v.e_ir = e_ir; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (reset && int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  initial begin
    // Same stimulus in both builds; expectations differ where in_ready differs.
`ifdef PIPE_STAGE_SKID_EN
    tbl[0]  = mk(0, 1, 8'h11, 1, 2'd1, 1, 8'h11, 1, 4'd0);
    tbl[1]  = mk(0, 0, 8'h00, 1, 2'd0, 0, 8'h00, 1, 4'd0);
    tbl[2]  = mk(0, 1, 8'h0A, 0, 2'd1, 1, 8'h0A, 1, 4'd0);
    tbl[3]  = mk(0, 1, 8'h0B, 0, 2'd2, 1, 8'h0A, 0, 4'd1);
    tbl[4]  = mk(0, 1, 8'h0C, 0, 2'd2, 1, 8'h0A, 0, 4'd2);
    tbl[5]  = mk(0, 1, 8'h0C, 1, 2'd1, 1, 8'h0B, 1, 4'd2);
    tbl[6]  = mk(0, 0, 8'h00, 1, 2'd0, 0, 8'h00, 1, 4'd2);
    tbl[7]  = mk(0, 1, 8'h0C, 1, 2'd1, 1, 8'h0C, 1, 4'd2);
    tbl[8]  = mk(0, 1, 8'h0D, 0, 2'd2, 1, 8'h0C, 0, 4'd3);
    tbl[9]  = mk(1, 1, 8'hEE, 0, 2'd0, 0, 8'h00, 1, 4'd3);
    tbl[10] = mk(0, 0, 8'h00, 0, 2'd0, 0, 8'h00, 1, 4'd3);
`else
    tbl[0]  = mk(0, 1, 8'h11, 1, 2'd1, 1, 8'h11, 1, 4'd0);
    tbl[1]  = mk(0, 0, 8'h00, 1, 2'd0, 0, 8'h00, 1, 4'd0);
    tbl[2]  = mk(0, 1, 8'h0A, 0, 2'd1, 1, 8'h0A, 0, 4'd0);
    tbl[3]  = mk(0, 1, 8'h0B, 0, 2'd1, 1, 8'h0A, 0, 4'd1);
    tbl[4]  = mk(0, 1, 8'h0C, 0, 2'd1, 1, 8'h0A, 0, 4'd2);
    tbl[5]  = mk(0, 1, 8'h0C, 1, 2'd1, 1, 8'h0C, 1, 4'd2);
    tbl[6]  = mk(0, 0, 8'h00, 1, 2'd0, 0, 8'h00, 1, 4'd2);
    tbl[7]  = mk(0, 1, 8'h0C, 1, 2'd1, 1, 8'h0C, 1, 4'd2);
    tbl[8]  = mk(0, 1, 8'h0D, 0, 2'd1, 1, 8'h0C, 0, 4'd3);
    tbl[9]  = mk(1, 1, 8'hEE, 0, 2'd0, 0, 8'h00, 1, 4'd3);
    tbl[10] = mk(0, 0, 8'h00, 0, 2'd0, 0, 8'h00, 1, 4'd3);
`endif

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_out_data", 32'(out_data), 0);
    reset = 1'b1;
    step();
    chk("release_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 11; i++) begin
      flush = tbl[i].fl; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      step();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].e_stall));
      if (tbl[i].e_ov) chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_data));
    end

    // Stall-counter saturation: one entry held against back-pressure
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
    step();
    chk("sat_push_stall", 32'(stall_cnt), 3);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall", 32'(stall_cnt), 15);
    chk("sat_out_data", 32'(out_data), 32'h55);

    // in_ready reaction to out_ready with no clock edge
    in_valid = 1'b1; in_data = 8'h66;
    step();
    in_valid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    chk("full_count", 32'(count), 2);
    out_ready = 1'b1;
    #1;
    chk("ready_registered", 32'(in_ready), 0);
`else
    chk("single_count", 32'(count), 1);
    out_ready = 1'b1;
    #1;
    chk("ready_comb", 32'(in_ready), 1);
`endif
    out_ready = 1'b0;
    #1;

    // Asynchronous reset between edges with a live, stalled entry
    reset = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_stall", 32'(stall_cnt), 0);
    chk("async_count", 32'(count), 0);
    chk("async_out_data", 32'(out_data), 0);
    chk("async_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    chk("rerelease_in_ready", 32'(in_ready), 1);
    chk("rerelease_out_valid", 32'(out_valid), 0);

    // Full-rate stream: one transfer per cycle, in order, latency one
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_data = 8'(k);
      step();
      chk($sformatf("stream%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("stream%0d_data", k), 32'(out_data), 32'(k));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_count", 32'(count), 0);
    chk("stream_stall", 32'(stall_cnt), 0);

`ifndef PIPE_STAGE_SKID_EN
    chk("single_max_count", 32'(max_cnt), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
